eth_mdio_master: RTL and testbench
==================================

Name: eth_mdio_master

Overview:
Parametrised MDIO management master (IEEE 802.3 Clause 22 and Clause 45) in the clk_mac domain, driving the PHY MDC/MDIO pins. It generalises the existing single-mode SMI engine with a configurable MDC divider, configurable or suppressed preamble, and Clause 45 opcodes. It adds a separate response channel with a turnaround-based "no PHY" error flag. Sits between the MAC control/CSR logic and the board PHY pins.

Parameters:
CLK_DIV, 10, clk_mac cycles per MDC half-period (≥2); MDC = clk_mac/(2*CLK_DIV)
PREAMBLE_LEN, 32, number of leading 1 bits per frame; 0 = preamble suppression
C45_EN, 1, 1 = Clause 45 frames accepted; 0 = C45 commands rejected with error

Ports:
clk_mac  in  1  system/MAC clock
rst_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
cmd_c45  in  1  0 = Clause 22 frame (ST=01), 1 = Clause 45 frame (ST=00)
cmd_op  in  2  C22: 01 write, 10 read; C45: 00 address, 01 write, 11 read, 10 post-read-increment
cmd_phyaddr  in  5  PHYAD / PRTAD
cmd_regaddr  in  5  REGAD (C22) / DEVAD (C45)
cmd_data  in  16  write data or C45 address
rsp_valid  out  1  one-cycle pulse per accepted command
rsp_err  out  1  valid with rsp_valid: illegal command, or TA bit 2 not driven low on a read
rsp_data  out  16  read data; updated only by read-type ops; holds otherwise
eth_mdc  out  1  management clock, free-running
eth_mdio  inout  1  management data; hi-Z when not driving

Behaviour:
- Reset (rst_n=0 at clk_mac edge): state IDLE, divider count 0, eth_mdc=0, eth_mdio hi-Z, cmd_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_data=0. Reset mid-frame aborts immediately with no response.
- MDC: divider counts 0..CLK_DIV-1 and toggles eth_mdc on wrap. fall_tick = wrap while mdc=1; rise_tick = wrap while mdc=0. The FSM advances only on ticks. Drive changes on fall_tick; sampling on rise_tick.
- Handshake: accept on cmd_valid && cmd_ready. Fields are latched; inputs are don't-care afterwards. cmd_ready drops the cycle after accept.
- Illegal command: C22 with op 00/11, or cmd_c45=1 with C45_EN=0. No frame is sent; rsp_valid=1, rsp_err=1 on the cycle after accept; return to IDLE.
- Frame: PREAMBLE_LEN×1, ST(2), OP(2), PHYAD(5), REG/DEVAD(5), TA(2), DATA(16), MSB first.
- Read-type op (C22 10, C45 11/10): master drives bits up to REG/DEVAD, then releases from the first TA bit.
- All other ops: master drives TA=10 and cmd_data.
- FSM states:
  - IDLE
  - SHIFT: first bit driven at the first fall_tick after accept; one bit per fall_tick; a 6-bit counter tracks bits in the current field group.
  - TA_RD: reads only. Sample on the 2nd TA rise_tick; value 1 sets an internal err flag.
  - READ: 16 rise_tick samples shifted into a 16-bit register, MSB first.
  - GAP: mdio hi-Z for one full MDC period (two ticks).
  - RESP: one cycle. rsp_valid=1 with rsp_err=err; rsp_data loads on reads even when err=1 (typically 0xFFFF via pull-up). Then IDLE.
- Frame length: PREAMBLE_LEN+32 MDC periods. Accept-to-rsp_valid ≤ (PREAMBLE_LEN+34)×2×CLK_DIV + CLK_DIV + 2 clk_mac cycles.
- New cmd_valid during a frame: held off by cmd_ready=0. A command presented in the RESP cycle is not accepted until the following IDLE cycle.
- PREAMBLE_LEN=0: frame begins directly with ST.
- Bit counters must be sized for PREAMBLE_LEN up to 63 without overflow.

Decomposition:
- Package eth_mdio_pkg holds:
  - ST constants (ST_C22=2'b01, ST_C45=2'b00).
  - Op constants (C22_WR, C22_RD, C45_ADDR, C45_WR, C45_RD, C45_RDINC).
  - State enum.
  - is_read_op function.
- Sub-module eth_mdc_gen (CLK_DIV): produces eth_mdc, fall_tick, rise_tick; reset mdc=0.

Test Plan:
- CLK_DIV=4, PREAMBLE_LEN=32. C22 write phy=1, reg=0x00, data=0x1140 → 64 bits sampled on MDC rising edges = 32×1, 01 01 00001 00000 10 0001000101000000. Then rsp_valid once with rsp_err=0.
- C22 read phy=1, reg=0x02 with PHY model driving TA=z0 and 0x0022 → master hi-Z from TA bit 1; rsp_data=0x0022, rsp_err=0.
- C22 read with no PHY (pull-up) → rsp_err=1, rsp_data=0xFFFF, cmd_ready returns high.
- C45 address (devad=1, data=0x0007), then C45 read → ST=00, OP=00 then 11. PHY returns 0xABCD → rsp_data=0xABCD. Rerun with C45_EN=0 → immediate rsp_err=1, MDIO never driven.
- PREAMBLE_LEN=0 write → exactly 32 MDC periods of driven data; C22 op 11 → error pulse the cycle after accept.
- rst_n low for 1 cycle at bit 20 of a read → mdio hi-Z and mdc=0 next cycle, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/eth_mdio_pkg.sv
// rtl/eth_mdio_pkg.sv - shared constants, state encoding and op decode for the MDIO master
package eth_mdio_pkg;

  // Start-of-frame codes
  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  // Opcodes (Clause 22 and Clause 45 share the 2-bit field)
  localparam logic [1:0] C22_WR    = 2'b01;
  localparam logic [1:0] C22_RD    = 2'b10;
  localparam logic [1:0] C45_ADDR  = 2'b00;
  localparam logic [1:0] C45_WR    = 2'b01;
  localparam logic [1:0] C45_RD    = 2'b11;
  localparam logic [1:0] C45_RDINC = 2'b10;

  // Turnaround pattern when the master keeps driving
  localparam logic [1:0] TA_WR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_TA_RD,
    S_READ,
    S_GAP,
    S_RESP
  } mdio_state_e;

  // Read-type ops hand the bus to the PHY from the first TA bit onward
  function automatic logic is_read_op(input logic c45, input logic [1:0] op);
    if (c45) begin
      return (op == C45_RD) || (op == C45_RDINC);
    end
    return op == C22_RD;
  endfunction

endpackage

// File: rtl/eth_mdc_gen.sv
// rtl/eth_mdc_gen.sv - free-running MDC divider with fall/rise tick strobes
module eth_mdc_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk_mac,
  input  logic rst_n,
  output logic eth_mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap      = (cnt == CNT_LAST);
  // Ticks mark the clk_mac edge on which MDC is about to change level
  assign fall_tick = wrap & eth_mdc;
  assign rise_tick = wrap & ~eth_mdc;

  // Half-period counter; MDC toggles on every wrap
  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      cnt     <= '0;
      eth_mdc <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      eth_mdc <= ~eth_mdc;
    end else begin
      cnt     <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/eth_mdio_master.sv
// rtl/eth_mdio_master.sv - Clause 22/45 MDIO management master with response channel
module eth_mdio_master
  import eth_mdio_pkg::*;
#(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32,
  parameter int C45_EN       = 1
) (
  input  logic        clk_mac,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phyaddr,
  input  logic [4:0]  cmd_regaddr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic        eth_mdc,
  inout  wire         eth_mdio
);

  localparam logic       PRE_ON   = (PREAMBLE_LEN != 0);
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);
  // ST+OP+PHYAD+REGAD bits driven before a read releases the bus
  localparam logic [5:0] RD_HDR   = 6'd14;
  localparam logic [5:0] FRM_BITS = 6'd32;

  mdio_state_e state, state_next;

  logic        fall_tick, rise_tick, tick;
  logic [31:0] frame_q;
  logic        rd_q;
  logic        err_q;
  logic        in_pre;
  logic [5:0]  bit_cnt;
  logic        gap_q;
  logic [15:0] shreg;
  logic [15:0] rsp_data_q;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic        legal;
  logic        body_done;

  eth_mdc_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_mdc (
    .clk_mac  (clk_mac),
    .rst_n    (rst_n),
    .eth_mdc  (eth_mdc),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick)
  );

  assign tick     = fall_tick | rise_tick;
  assign eth_mdio = mdio_oe ? mdio_out : 1'bz;
  assign mdio_in  = eth_mdio;
  assign rsp_data = rsp_data_q;

  assign legal     = cmd_c45 ? (C45_EN != 0) : ((cmd_op == C22_WR) || (cmd_op == C22_RD));
  // Reads stop driving after the header; writes after the full 32-bit body
  assign body_done = !in_pre && (rd_q ? (bit_cnt == RD_HDR) : (bit_cnt == FRM_BITS));

  // State register
  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = legal ? S_SHIFT : S_RESP;
        end
      end
      S_SHIFT: begin
        if (fall_tick && body_done) begin
          state_next = rd_q ? S_TA_RD : S_GAP;
        end
      end
      S_TA_RD: begin
        if (rise_tick && (bit_cnt == 6'd1)) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        if (rise_tick && (bit_cnt == 6'd15)) begin
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (tick && gap_q) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Frame shifter, turnaround check, read capture and response data
  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      frame_q    <= '0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      in_pre     <= 1'b0;
      bit_cnt    <= '0;
      gap_q      <= 1'b0;
      shreg      <= '0;
      rsp_data_q <= '0;
      mdio_out   <= 1'b0;
      mdio_oe    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            frame_q <= {(cmd_c45 ? ST_C45 : ST_C22), cmd_op, cmd_phyaddr,
                        cmd_regaddr, TA_WR, cmd_data};
            rd_q    <= is_read_op(cmd_c45, cmd_op);
            err_q   <= !legal;
            in_pre  <= PRE_ON;
            bit_cnt <= '0;
            gap_q   <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (fall_tick) begin
            if (in_pre) begin
              mdio_oe  <= 1'b1;
              mdio_out <= 1'b1;
              if (bit_cnt == PRE_LAST) begin
                in_pre  <= 1'b0;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end else if (body_done) begin
              mdio_oe <= 1'b0;
              bit_cnt <= '0;
            end else begin
              mdio_oe  <= 1'b1;
              mdio_out <= frame_q[31];
              frame_q  <= {frame_q[30:0], 1'b0};
              bit_cnt  <= bit_cnt + 6'd1;
            end
          end
        end
        S_TA_RD: begin
          if (rise_tick) begin
            if (bit_cnt == 6'd1) begin
              err_q   <= err_q | mdio_in;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        S_READ: begin
          if (rise_tick) begin
            shreg   <= {shreg[14:0], mdio_in};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        S_GAP: begin
          if (tick) begin
            gap_q <= 1'b1;
            if (gap_q && rd_q) begin
              rsp_data_q <= shreg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mdio_master.sv
// tb/tb_eth_mdio_master.sv - directed self-checking bench for eth_mdio_master
module tb_eth_mdio_master;
  import eth_mdio_pkg::*;

  localparam int DIV   = 4;
  localparam int LAT_A = (32 + 34) * 2 * DIV + DIV + 2;
  localparam int LAT_B = (0 + 34) * 2 * DIV + DIV + 2;

  logic        clk_mac = 1'b0;
  logic        rst_n   = 1'b0;
  logic        cmd_c45 = 1'b0;
  logic [1:0]  cmd_op  = 2'b00;
  logic [4:0]  cmd_phyaddr = '0;
  logic [4:0]  cmd_regaddr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
  logic        cmd_ready_a, cmd_ready_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic        rsp_err_a, rsp_err_b;
  logic [15:0] rsp_data_a, rsp_data_b;
  logic        mdc_a, mdc_b;
  wire         mdio_a, mdio_b;

  int checks = 0;
  int errors = 0;

  // PHY model on bus A
  logic        phy_en = 1'b0;
  logic [15:0] phy_word = '0;
  logic        phy_oe = 1'b0, phy_out = 1'b0;

  pullup (mdio_a);
  pulldown (mdio_b);
  assign mdio_a = (phy_en && phy_oe) ? phy_out : 1'bz;

  always #5 clk_mac = ~clk_mac;

  eth_mdio_master #(.CLK_DIV(DIV), .PREAMBLE_LEN(32), .C45_EN(1)) dut_a (
    .clk_mac(clk_mac), .rst_n(rst_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_c45(cmd_c45),
    .cmd_op(cmd_op), .cmd_phyaddr(cmd_phyaddr), .cmd_regaddr(cmd_regaddr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a),
    .rsp_data(rsp_data_a), .eth_mdc(mdc_a), .eth_mdio(mdio_a)
  );

  eth_mdio_master #(.CLK_DIV(DIV), .PREAMBLE_LEN(0), .C45_EN(0)) dut_b (
    .clk_mac(clk_mac), .rst_n(rst_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_c45(cmd_c45),
    .cmd_op(cmd_op), .cmd_phyaddr(cmd_phyaddr), .cmd_regaddr(cmd_regaddr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b),
    .rsp_data(rsp_data_b), .eth_mdc(mdc_b), .eth_mdio(mdio_b)
  );

  // Bus A recorder and PHY: arm on first MDC fall after a request, sample on rises
  int          req_a = 0, seen_a = 0, ncap_a = 0;
  logic        rec_a = 1'b0;
  logic [63:0] cap_a = '0;
  always @(mdc_a) begin
    if (mdc_a) begin
      if (rec_a && ncap_a < 64) begin
        cap_a  = {cap_a[62:0], mdio_a};
        ncap_a = ncap_a + 1;
      end
    end else begin
      if (req_a != seen_a) begin
        seen_a = req_a;
        ncap_a = 0;
        cap_a  = '0;
        rec_a  = 1'b1;
      end
      if (ncap_a == 47) begin
        phy_oe  = 1'b1;
        phy_out = 1'b0;
      end else if (ncap_a >= 48 && ncap_a <= 63) begin
        phy_oe  = 1'b1;
        phy_out = phy_word[63 - ncap_a];
      end else begin
        phy_oe  = 1'b0;
      end
    end
  end

  // Bus B recorder (32-bit frames) and count of sampled ones
  int          req_b = 0, seen_b = 0, ncap_b = 0, ones_b = 0;
  logic        rec_b = 1'b0;
  logic [31:0] cap_b = '0;
  always @(mdc_b) begin
    if (mdc_b) begin
      if (mdio_b) ones_b = ones_b + 1;
      if (rec_b && ncap_b < 32) begin
        cap_b  = {cap_b[30:0], mdio_b};
        ncap_b = ncap_b + 1;
      end
    end else if (req_b != seen_b) begin
      seen_b = req_b;
      ncap_b = 0;
      cap_b  = '0;
      rec_b  = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit sel_b, input logic c45, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] rega, input logic [15:0] data);
    @(negedge clk_mac);
    chk("cmd_ready_before", 64'(sel_b ? cmd_ready_b : cmd_ready_a), 64'd1);
    cmd_c45 = c45; cmd_op = op; cmd_phyaddr = phy; cmd_regaddr = rega; cmd_data = data;
    if (sel_b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    @(negedge clk_mac);
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_data = 16'hDEAD; cmd_op = 2'b11; cmd_phyaddr = 5'h1F;
    if (sel_b) req_b++; else req_a++;
  endtask

  task automatic wait_rsp(input bit sel_b, input int budget, output bit got,
                          output logic err, output logic [15:0] data, output int cyc);
    got = 1'b0; err = 1'b0; data = '0; cyc = 0;
    while (!got && cyc <= budget) begin
      if (sel_b ? rsp_valid_b : rsp_valid_a) begin
        got  = 1'b1;
        err  = sel_b ? rsp_err_b : rsp_err_a;
        data = sel_b ? rsp_data_b : rsp_data_a;
      end else begin
        @(negedge clk_mac);
        cyc++;
      end
    end
  endtask

  // Full bus-A transaction with response, latency, pulse-width and bit-stream checks
  task automatic run_a(input string tag, input logic c45, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] rega, input logic [15:0] data,
                       input logic exp_err, input logic [15:0] exp_data, input logic [63:0] exp_cap);
    bit got; logic err; logic [15:0] rd; int cyc;
    issue(1'b0, c45, op, phy, rega, data);
    chk({tag, "_busy"}, 64'(cmd_ready_a), 64'd0);
    wait_rsp(1'b0, LAT_A, got, err, rd, cyc);
    chk({tag, "_rsp_seen"}, 64'(got), 64'd1);
    chk({tag, "_lat_ok"}, 64'(cyc <= LAT_A), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_data"}, 64'(rd), 64'(exp_data));
    chk({tag, "_nbits"}, 64'(ncap_a), 64'd64);
    chk({tag, "_bits"}, cap_a, exp_cap);
    @(negedge clk_mac);
    chk({tag, "_pulse_end"}, 64'(rsp_valid_a), 64'd0);
    chk({tag, "_ready_back"}, 64'(cmd_ready_a), 64'd1);
  endtask

  initial begin
    bit got; logic err; logic [15:0] rd; int cyc; int n; int o0; bit saw;

    repeat (3) @(negedge clk_mac);
    rst_n = 1'b1;
    chk("rst_ready_a", 64'(cmd_ready_a), 64'd1);
    chk("rst_valid_a", 64'(rsp_valid_a), 64'd0);
    chk("rst_err_a", 64'(rsp_err_a), 64'd0);
    chk("rst_data_a", 64'(rsp_data_a), 64'd0);
    chk("rst_mdc_a", 64'(mdc_a), 64'd0);
    chk("rst_mdio_a", 64'(mdio_a), 64'd1);
    chk("rst_ready_b", 64'(cmd_ready_b), 64'd1);
    chk("rst_mdio_b", 64'(mdio_b), 64'd0);

    // Clause 22 write
    run_a("c22_wr", 1'b0, C22_WR, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0000,
          {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140});

    // Clause 22 read with PHY answering 0x0022
    phy_en = 1'b1; phy_word = 16'h0022;
    run_a("c22_rd", 1'b0, C22_RD, 5'd1, 5'd2, 16'h0000, 1'b0, 16'h0022,
          {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0022});

    // Clause 22 read with no PHY: pull-up on TA and data
    phy_en = 1'b0;
    run_a("c22_nophy", 1'b0, C22_RD, 5'd1, 5'd2, 16'h0000, 1'b1, 16'hFFFF,
          {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 2'b11, 16'hFFFF});

    // Clause 45 address: not a read, rsp_data holds previous value
    run_a("c45_addr", 1'b1, C45_ADDR, 5'd1, 5'd1, 16'h0007, 1'b0, 16'hFFFF,
          {32'hFFFF_FFFF, 2'b00, 2'b00, 5'd1, 5'd1, 2'b10, 16'h0007});

    // Clause 45 read returning 0xABCD
    phy_en = 1'b1; phy_word = 16'hABCD;
    run_a("c45_rd", 1'b1, C45_RD, 5'd1, 5'd1, 16'h0000, 1'b0, 16'hABCD,
          {32'hFFFF_FFFF, 2'b00, 2'b11, 5'd1, 5'd1, 2'b10, 16'hABCD});
    phy_en = 1'b0;

    // Bus B: Clause 45 rejected when disabled; nothing driven
    o0 = ones_b;
    issue(1'b1, 1'b1, C45_RD, 5'd31, 5'd31, 16'hFFFF);
    wait_rsp(1'b1, 2, got, err, rd, cyc);
    chk("c45_off_seen", 64'(got), 64'd1);
    chk("c45_off_cyc", 64'(cyc), 64'd0);
    chk("c45_off_err", 64'(err), 64'd1);
    chk("c45_off_data", 64'(rd), 64'd0);
    @(negedge clk_mac);
    chk("c45_off_ready", 64'(cmd_ready_b), 64'd1);

    // Bus B: Clause 22 op 11 is illegal
    issue(1'b1, 1'b0, 2'b11, 5'd31, 5'd31, 16'hFFFF);
    wait_rsp(1'b1, 2, got, err, rd, cyc);
    chk("c22_op11_cyc", 64'(cyc), 64'd0);
    chk("c22_op11_err", 64'(err), 64'd1);
    repeat (100) @(negedge clk_mac);
    chk("illegal_no_drive", 64'(ones_b - o0), 64'd0);

    // Bus B: preamble suppressed write, 32 driven bits
    issue(1'b1, 1'b0, C22_WR, 5'd3, 5'd4, 16'hA5C3);
    wait_rsp(1'b1, LAT_B, got, err, rd, cyc);
    chk("nopre_seen", 64'(got), 64'd1);
    chk("nopre_lat_ok", 64'(cyc <= LAT_B), 64'd1);
    chk("nopre_err", 64'(err), 64'd0);
    chk("nopre_nbits", 64'(ncap_b), 64'd32);
    chk("nopre_bits", 64'(cap_b), 64'({2'b01, 2'b01, 5'd3, 5'd4, 2'b10, 16'hA5C3}));

    // Reset during bit 20 of a read aborts with no response
    phy_en = 1'b1; phy_word = 16'h5555;
    issue(1'b0, 1'b0, C22_RD, 5'd1, 5'd2, 16'h0000);
    n = 0;
    while (ncap_a < 20 && n < 2000) begin
      @(negedge clk_mac);
      n++;
    end
    chk("abort_reach_bit20", 64'(ncap_a >= 20), 64'd1);
    rst_n = 1'b0;
    @(negedge clk_mac);
    phy_en = 1'b0;
    chk("abort_mdc", 64'(mdc_a), 64'd0);
    chk("abort_mdio", 64'(mdio_a), 64'd1);
    chk("abort_valid", 64'(rsp_valid_a), 64'd0);
    rst_n = 1'b1;
    chk("abort_ready", 64'(cmd_ready_a), 64'd1);
    saw = 1'b0;
    repeat (LAT_A + 20) begin
      @(negedge clk_mac);
      if (rsp_valid_a) saw = 1'b1;
    end
    chk("abort_no_rsp", 64'(saw), 64'd0);

    // Recovery: normal write after the abort
    run_a("post_rst_wr", 1'b0, C22_WR, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0000,
          {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
